// File: rtl/chaotic_stream_cipher.sv
// Chaotic stream cipher: fixed-point logistic-map keystream with periodic alpha
// perturbation, keyed warm-up, OFB/CFB feedback and valid/ready on both sides.
module chaotic_stream_cipher #(
    parameter int DATA_WIDTH   = 8,
    parameter int STATE_WIDTH  = 16,
    parameter int WARMUP_WIDTH = 8,
    parameter int PERTURB_LOG  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  key_valid,
    input  logic [3*STATE_WIDTH+WARMUP_WIDTH-1:0] key,
    input  logic [1:0]                            mode,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  busy
);
    localparam int SW = STATE_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int WW = WARMUP_WIDTH;

    if (SW < DW + 2) begin : g_width_check
        $error("STATE_WIDTH must be at least DATA_WIDTH + 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [SW-1:0] x;
    logic [SW-1:0] it;
    logic [SW-1:0] mu;
    logic [SW-1:0] alpha;
    logic [1:0]    mode_q;
    logic [WW-1:0] warm_cnt;

    logic [SW-1:0] key_mu;
    logic [SW-1:0] key_x0;
    logic [SW-1:0] key_alpha;
    logic [WW-1:0] key_k;

    logic [DW-1:0] ks;
    logic [DW-1:0] res;
    logic [DW-1:0] fb;
    logic [SW-1:0] map_in;
    logic [SW-1:0] step_x;
    logic          perturb;
    logic          accept;

    assign {key_mu, key_x0, key_alpha, key_k} = key;

    // One logistic-map iteration including perturbation and zero lock-out.
    function automatic logic [SW-1:0] map_step(
        input logic [SW-1:0] xv,
        input logic [SW-1:0] muv,
        input logic [SW-1:0] av,
        input logic          pert
    );
        logic [2*SW-1:0] prod_a;
        logic [2*SW-1:0] prod_b;
        logic [SW-1:0]   t;
        logic [SW-1:0]   nx;
        // 2^SW-1-x is simply the bitwise complement of x.
        prod_a = {{SW{1'b0}}, xv} * {{SW{1'b0}}, ~xv};
        t      = SW'(prod_a >> SW);
        prod_b = {{SW{1'b0}}, muv} * {{SW{1'b0}}, t};
        nx     = SW'(prod_b >> (SW - 2));
        if (pert) begin
            nx = nx ^ av;
        end
        if (nx == '0) begin
            nx = av | SW'(1);
        end
        return nx;
    endfunction

    assign ks       = x[SW-1 -: DW];
    assign res      = in_data ^ ks;
    assign fb       = mode_q[1] ? in_data : res;
    assign map_in   = (state == RUN && mode_q[0]) ? (x ^ {fb, {(SW-DW){1'b0}}}) : x;
    assign perturb  = &it[PERTURB_LOG-1:0];
    assign step_x   = map_step(map_in, mu, alpha, perturb);

    assign in_ready = (state == RUN) && !key_valid && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == WARMUP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (key_valid) begin
            state_next = (key_k == '0) ? RUN : WARMUP;
        end else if (state == WARMUP && warm_cnt <= WW'(1)) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x         <= '0;
            it        <= '0;
            mu        <= '0;
            alpha     <= '0;
            mode_q    <= '0;
            warm_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        // NOTE: key load is tested first so it overrides both warm-up steps and acceptances.
        end else if (key_valid) begin
            mu        <= key_mu;
            x         <= key_x0;
            alpha     <= key_alpha;
            mode_q    <= mode;
            it        <= '0;
            warm_cnt  <= key_k;
            out_valid <= 1'b0;
        end else if (state == WARMUP) begin
            x        <= step_x;
            it       <= it + SW'(1);
            warm_cnt <= warm_cnt - WW'(1);
        end else if (accept) begin
            x         <= step_x;
            it        <= it + SW'(1);
            out_data  <= res;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_chaotic_stream_cipher.sv
// Self-checking bench for chaotic_stream_cipher: directed key scenarios plus
// random traffic compared against an arithmetic model of the logistic-map cipher.
module tb_chaotic_stream_cipher;
    localparam int DW = 8;
    localparam int SW = 16;
    localparam int WW = 8;
    localparam int PL = 4;
    localparam int KW = 3 * SW + WW;
    localparam longint unsigned MOD    = 64'd1 << SW;
    localparam longint unsigned PERIOD = 64'd1 << PL;
    localparam longint unsigned SCALE  = 64'd1 << (SW - DW);

    logic          clk = 1'b0;
    logic          rst;
    logic          key_valid;
    logic [KW-1:0] key;
    logic [1:0]    mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;

    always #5 clk = ~clk;

    chaotic_stream_cipher #(
        .DATA_WIDTH  (DW),
        .STATE_WIDTH (SW),
        .WARMUP_WIDTH(WW),
        .PERTURB_LOG (PL)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_valid(key_valid),
        .key      (key),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    longint unsigned m_x;
    longint unsigned m_it;
    longint unsigned m_mu;
    longint unsigned m_alpha;
    logic [1:0]      m_mode;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference map written as real-number arithmetic on integers.
    task automatic model_step(input longint unsigned xin);
        longint unsigned t;
        longint unsigned xn;
        t  = (xin * (MOD - 1 - xin)) / MOD;
        xn = ((m_mu * t) / (MOD / 4)) % MOD;
        if ((m_it % PERIOD) == PERIOD - 1) xn = xn ^ m_alpha;
        if (xn == 0) xn = m_alpha | 1;
        m_x  = xn;
        m_it = (m_it + 1) % MOD;
    endtask

    task automatic model_key(input logic [SW-1:0] k_mu, input logic [SW-1:0] k_x0,
                             input logic [SW-1:0] k_alpha, input logic [WW-1:0] k_k,
                             input logic [1:0] k_mode);
        m_mu    = 64'(k_mu);
        m_x     = 64'(k_x0);
        m_alpha = 64'(k_alpha);
        m_mode  = k_mode;
        m_it    = 0;
        repeat (int'(k_k)) model_step(m_x);
    endtask

    task automatic model_word(input logic [DW-1:0] pt, output logic [DW-1:0] res);
        longint unsigned ks;
        longint unsigned fb;
        longint unsigned xin;
        ks  = m_x / SCALE;
        res = pt ^ DW'(ks);
        fb  = m_mode[1] ? 64'(pt) : 64'(res);
        xin = m_mode[0] ? (m_x ^ (fb * SCALE)) : m_x;
        model_step(xin);
    endtask

    task automatic load_key(input logic [SW-1:0] k_mu, input logic [SW-1:0] k_x0,
                            input logic [SW-1:0] k_alpha, input logic [WW-1:0] k_k,
                            input logic [1:0] k_mode);
        key       = {k_mu, k_x0, k_alpha, k_k};
        mode      = k_mode;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        model_key(k_mu, k_x0, k_alpha, k_k, k_mode);
    endtask

    // Single handshaked word with out_ready held high.
    task automatic xfer(input logic [DW-1:0] pt, output logic [DW-1:0] res);
        int wait_cycles;
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        in_data     = pt;
        wait_cycles = 0;
        #1;
        while (!in_ready && wait_cycles < 300) begin
            @(posedge clk);
            #2;
            wait_cycles++;
        end
        check("xfer_ready_seen", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #1;
        check("xfer_out_valid", 32'(out_valid), 32'd1);
        res = out_data;
    endtask

    logic [DW-1:0] ct;
    logic [DW-1:0] exp_w;
    logic [DW-1:0] pt_w   [16];
    logic [DW-1:0] ct_cfb [16];
    logic [DW-1:0] ct_ofb [16];
    logic [DW-1:0] got    [16];
    logic [SW-1:0] r_mu;
    logic [SW-1:0] r_x0;
    logic [SW-1:0] r_alpha;
    logic [WW-1:0] r_k;
    int            guard;
    int            sent;
    int            got_n;
    int            n_acc;
    int            ndiff;
    logic          do_acc;

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        key       = '0;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_data", 32'(out_data), 32'd0);

        // OFB keystream from a hand-computed trajectory.
        load_key(16'hFFFF, 16'h8000, 16'h0000, 8'd0, 2'b00);
        #1;
        check("ofb_ready_k0", 32'(in_ready), 32'd1);
        xfer(8'h00, ct);
        check("ofb_w0", 32'(ct), 32'h80);
        xfer(8'h00, ct);
        check("ofb_w1", 32'(ct), 32'hFF);
        xfer(8'h00, ct);
        check("ofb_w2", 32'(ct), 32'h00);

        // Zero lock-out forces the state to alpha|1.
        load_key(16'hFFFF, 16'h0000, 16'h1234, 8'd0, 2'b00);
        xfer(8'h00, ct);
        check("lockout_w0", 32'(ct), 32'h00);
        xfer(8'h00, ct);
        check("lockout_w1", 32'(ct), 32'h12);
        model_word(8'h00, exp_w);
        model_word(8'h00, exp_w);
        model_word(8'h5A, exp_w);
        xfer(8'h5A, ct);
        check("lockout_w2", 32'(ct), 32'(exp_w));

        // Warm-up of five steps.
        r_mu    = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
        r_x0    = 16'($urandom_range(1, 16'hFFFF));
        r_alpha = 16'($urandom);
        load_key(r_mu, r_x0, r_alpha, 8'd5, 2'b00);
        for (int i = 0; i < 5; i++) begin
            check("warmup_busy", 32'(busy), 32'd1);
            check("warmup_not_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        check("warmup_busy_end", 32'(busy), 32'd0);
        check("warmup_ready_end", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            pt_w[i] = DW'($urandom);
            model_word(pt_w[i], exp_w);
            xfer(pt_w[i], ct);
            check("warmup_word", 32'(ct), 32'(exp_w));
        end

        // CFB encrypt, OFB with the same key, then CFB decrypt.
        r_mu    = 16'hE000 | 16'($urandom_range(0, 16'h1FFF));
        r_x0    = 16'($urandom_range(1, 16'hFFFF));
        r_alpha = 16'($urandom);
        r_k     = WW'($urandom_range(1, 20));
        load_key(r_mu, r_x0, r_alpha, r_k, 2'b01);
        for (int i = 0; i < 16; i++) begin
            pt_w[i] = DW'($urandom);
            model_word(pt_w[i], exp_w);
            xfer(pt_w[i], ct_cfb[i]);
            check("cfb_enc", 32'(ct_cfb[i]), 32'(exp_w));
        end
        load_key(r_mu, r_x0, r_alpha, r_k, 2'b00);
        for (int i = 0; i < 16; i++) begin
            model_word(pt_w[i], exp_w);
            xfer(pt_w[i], ct_ofb[i]);
            check("ofb_enc", 32'(ct_ofb[i]), 32'(exp_w));
        end
        check("cfb_ofb_w0_same", 32'(ct_cfb[0]), 32'(ct_ofb[0]));
        ndiff = 0;
        for (int i = 1; i < 16; i++) begin
            if (ct_cfb[i] != ct_ofb[i]) ndiff++;
        end
        check("cfb_ofb_differ", 32'(ndiff >= 10), 32'd1);
        load_key(r_mu, r_x0, r_alpha, r_k, 2'b11);
        for (int i = 0; i < 16; i++) begin
            xfer(ct_cfb[i], ct);
            check("cfb_dec", 32'(ct), 32'(pt_w[i]));
        end

        // Back-pressure: one acceptance while stalled, then full rate.
        load_key(r_mu, r_x0, r_alpha, r_k, 2'b00);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pt_w[0];
        guard     = 0;
        #1;
        while (!in_ready && guard < 300) begin
            @(posedge clk);
            #2;
            guard++;
        end
        check("bp_ready_seen", 32'(in_ready), 32'd1);
        sent  = 0;
        got_n = 0;
        n_acc = 0;
        for (int cyc = 0; cyc < 100 && got_n < 16; cyc++) begin
            out_ready = (cyc >= 11);
            #1;
            if (cyc >= 1 && cyc <= 10) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_out_stable", 32'(out_data), 32'(ct_ofb[0]));
            end
            if (cyc <= 10 && in_valid && in_ready) n_acc++;
            if (cyc >= 11 && sent < 16) check("bp_full_rate", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) begin
                got[got_n] = out_data;
                got_n++;
            end
            do_acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (do_acc) begin
                sent++;
                if (sent < 16) in_data = pt_w[sent];
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        check("bp_accepts_in_stall", 32'(n_acc), 32'd1);
        check("bp_word_count", 32'(got_n), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("bp_word", 32'(got[i]), 32'(ct_ofb[i]));
        end

        // Key load colliding with an input word in RUN.
        load_key(r_mu, r_x0, r_alpha, 8'd0, 2'b00);
        model_word(pt_w[0], exp_w);
        xfer(pt_w[0], ct);
        check("mid_first", 32'(ct), 32'(exp_w));
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = pt_w[1];
        key       = {r_mu, r_x0, r_alpha, 8'd0};
        mode      = 2'b00;
        key_valid = 1'b1;
        #1;
        check("mid_pending", 32'(out_valid), 32'd1);
        check("mid_in_ready_low", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        model_key(r_mu, r_x0, r_alpha, 8'd0, 2'b00);
        #1;
        check("mid_out_valid_drop", 32'(out_valid), 32'd0);
        model_word(pt_w[1], exp_w);
        xfer(pt_w[1], ct);
        check("mid_restart_model", 32'(ct), 32'(exp_w));
        check("mid_restart_x0", 32'(ct), 32'(pt_w[1] ^ r_x0[SW-1 -: DW]));

        // Reset in the middle of a long warm-up.
        load_key(r_mu, r_x0, r_alpha, 8'd200, 2'b00);
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wu_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_wu_busy", 32'(busy), 32'd0);
        check("rst_wu_in_ready", 32'(in_ready), 32'd0);
        check("rst_wu_out_valid", 32'(out_valid), 32'd0);
        check("rst_wu_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_idle_busy", 32'(busy), 32'd0);
        check("rst_idle_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chaotic_stream_cipher.md
# chaotic_stream_cipher

Parametrised chaotic stream-cipher core. A fixed-point logistic map with periodic alpha perturbation produces the keystream, and the core XORs it with the data stream. Beyond plain XOR encryption it adds configurable state/data widths, a keyed warm-up phase, an output-feedback (OFB) or ciphertext-feedback (CFB) mode with encrypt/decrypt selection, and full valid/ready back-pressure on both sides. It is the drop-in successor to the current encryption top for streaming datapaths.

## Interface
- DATA_WIDTH, 8: plaintext/ciphertext word width.
- STATE_WIDTH, 16: map state width; must satisfy STATE_WIDTH >= DATA_WIDTH + 2.
- WARMUP_WIDTH, 8: width of the warm-up iteration count.
- PERTURB_LOG, 4: perturbation occurs once every 2^PERTURB_LOG iterations.
- clk  in  1  clock; all logic rises on posedge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  key load strobe; always accepted, single cycle.
- key  in  3*STATE_WIDTH+WARMUP_WIDTH  {mu, x0, alpha, k}, MSB first.
- mode  in  2  bit0 selects feedback (CFB); bit1 selects decrypt. Latched with the key.
- in_valid / in_ready  in / out  1  input handshake.
- in_data  in  DATA_WIDTH  plaintext, or ciphertext when decrypting.
- out_valid / out_ready  out / in  1  output handshake.
- out_data  out  DATA_WIDTH  result word.
- busy  out  1  high while in WARMUP.

## Operation
- Fixed-point formats:
  - x is Q0.SW, unsigned, where SW = STATE_WIDTH.
  - mu is Q2.(SW-2).
  - F(x): t = (x * (2^SW-1-x)) >> SW, kept to SW bits; x' = (mu * t) >> (SW-2), truncated to SW bits.
- Perturbation:
  - An iteration counter `it` (SW bits, wrapping) increments on every map step.
  - If it[PERTURB_LOG-1:0] is all ones before the increment, x' ^= alpha.
- Zero lock-out:
  - Applied after perturbation.
  - If x' == 0, x' = alpha | 1.
- Keystream word: ks = x[SW-1 -: DATA_WIDTH], taken from the current state before the step.
- States:
  - IDLE: entered after reset. in_ready=0.
  - WARMUP: performs one step per cycle for k cycles, with no output. Moves to RUN when the remaining count hits 0.
  - RUN: one step per accepted input word.
- Key load, on a cycle with key_valid=1:
  - Latch mu, alpha, mode.
  - Set x = x0, it = 0, and the warm-up count = k.
  - Clear out_valid; any pending word is discarded.
  - Go to WARMUP, or straight to RUN if k == 0.
  - Key load wins over every other event in that cycle, including an input acceptance and a WARMUP step.
- Accept condition: state==RUN && in_valid && in_ready.
  - res = in_data ^ ks, loaded into out_data, and out_valid is set.
  - OFB (mode[0]=0): x <= F(x).
  - CFB (mode[0]=1): fb = mode[1] ? in_data : res, then x <= F(x ^ {fb, {SW-DATA_WIDTH{1'b0}}}).
- in_ready = (state==RUN) && !key_valid && (!out_valid || out_ready). It is combinational.
- out_valid clears on out_ready when no new word is accepted in the same cycle.
- The map only advances on acceptance. A stalled output freezes the keystream.

## Timing
- Reset values:
  - state=IDLE, x=0, it=0, mu=0, alpha=0, mode=0.
  - out_valid=0, out_data=0, busy=0, in_ready=0.
- Reset mid-operation discards the key, the state and any pending output. The core returns to IDLE.
- Key-load latency:
  - Key load at cycle T, with k>0: busy=1 from T+1 through T+k.
  - The first in_ready=1 is at cycle T+1+k.
  - With k=0, in_ready=1 at T+1.
- Data latency: out_valid rises one cycle after acceptance.
- Throughput: one word per cycle while out_ready is held at 1.
- Back-pressure:
  - With out_valid=1 and out_ready=0, in_ready=0.
  - out_data stays stable until the handshake completes.
- Simultaneous out handshake and new acceptance: out_valid stays 1 and out_data takes the new word.
- `it` wraps from 2^SW-1 to 0 silently.
- Warm-up steps count toward the perturbation schedule.

## Test plan
- OFB keystream, SW=16, DW=8:
  - Stimulus: mu=0xFFFF, x0=0x8000, alpha=0, k=0, mode=00, pt = 0x00, 0x00, 0x00.
  - Required: out = 0x80, 0xFF, 0x00 (state sequence 0x8000 → 0xFFFB → 0x000B).
- Zero lock-out:
  - Stimulus: x0=0x0000, alpha=0x1234, k=0, pt = 0x00, 0x00.
  - Required: out = 0x00, 0x12 (state becomes 0x1235).
- Warm-up:
  - Stimulus: k=5, key_valid at cycle T.
  - Required: busy high for cycles T+1..T+5; in_ready first high at T+6; the first output equals the keystream after 5 steps.
- CFB round trip:
  - Stimulus: encrypt 16 random words with mode=01, reload the same key with mode=11, and feed the ciphertext back in.
  - Required: the recovered words equal the originals; the OFB and CFB ciphertexts differ from word 2 onward.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 10 cycles with in_valid=1.
  - Required: exactly one word is accepted and out_data is stable. After release, the output sequence is identical to the unstalled run.
- Key mid-stream and reset:
  - Stimulus: assert key_valid together with in_valid in RUN.
  - Required: no acceptance in that cycle, out_valid drops, and the stream restarts from x0.
  - Stimulus: assert rst during WARMUP.
  - Required: IDLE, and all outputs return to 0.
